// File: rtl/sine_pkg.sv
// sine_pkg: shared envelope state encoding, frame phase map and DAC midscale.
package sine_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;
    localparam logic [7:0] PH_CAPTURE   = 8'd9;
    localparam logic [7:0] PH_MUL_FIRST = 8'd10;
    localparam logic [7:0] PH_MUL_LAST  = 8'd16;
    localparam logic [7:0] PH_OUT       = 8'd17;
    localparam logic [6:0] MIDSCALE     = 7'd64;
endpackage

// File: rtl/adsr_fsm.sv
// adsr_fsm: gate-driven ADSR accumulator, advanced once per frame when en is high.
module adsr_fsm
    import sine_pkg::*;
#(
    parameter int ENV_BITS  = 12,
    parameter int RATE_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 gate,
    input  logic [RATE_BITS-1:0] attack_rate,
    input  logic [RATE_BITS-1:0] decay_rate,
    input  logic [RATE_BITS-1:0] sustain_level,
    input  logic [RATE_BITS-1:0] release_rate,
    output logic [2:0]           env_state,
    output logic [6:0]           env_level
);
    localparam int AW = ENV_BITS + 1;
    localparam logic [ENV_BITS-1:0] ACC_MAX = '1;
    function automatic logic [RATE_BITS:0] step(input logic [RATE_BITS-1:0] r);
        return {1'b0, r} + 1'b1;
    endfunction
    env_state_t state_q, state_d;
    logic [ENV_BITS-1:0] acc_q, acc_d, target, attack_acc;
    logic [AW-1:0] up, dn_decay, dn_release;
    logic attack_sat, decay_hit, release_zero;
    // One spare top bit on each path catches overflow/underflow so steps saturate instead of wrapping.
    assign target       = {sustain_level, {(ENV_BITS-RATE_BITS){1'b0}}};
    assign up           = {1'b0, acc_q} + AW'(step(attack_rate));
    assign dn_decay     = {1'b0, acc_q} - AW'(step(decay_rate));
    assign dn_release   = {1'b0, acc_q} - AW'(step(release_rate));
    assign attack_sat   = up[ENV_BITS] || up[ENV_BITS-1:0] == ACC_MAX;
    assign attack_acc   = attack_sat ? ACC_MAX : up[ENV_BITS-1:0];
    assign decay_hit    = dn_decay[ENV_BITS] || dn_decay[ENV_BITS-1:0] <= target;
    assign release_zero = dn_release[ENV_BITS] || dn_release[ENV_BITS-1:0] == '0;
    always_comb begin
        acc_d   = acc_q;
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    acc_d   = '0;
                    state_d = gate ? ATTACK : IDLE;
                end
                ATTACK: begin
                    acc_d   = attack_acc;
                    state_d = !gate ? RELEASE : attack_sat ? DECAY : ATTACK;
                end
                DECAY: begin
                    acc_d   = decay_hit ? target : dn_decay[ENV_BITS-1:0];
                    state_d = !gate ? RELEASE : decay_hit ? SUSTAIN : DECAY;
                end
                SUSTAIN: begin
                    acc_d   = target;
                    state_d = gate ? SUSTAIN : RELEASE;
                end
                RELEASE: begin
                    acc_d   = gate ? attack_acc : release_zero ? '0 : dn_release[ENV_BITS-1:0];
                    state_d = gate ? ATTACK : release_zero ? IDLE : RELEASE;
                end
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            state_q <= IDLE;
        end else begin
            acc_q   <= acc_d;
            state_q <= state_d;
        end
    end
    assign env_state = state_q;
    assign env_level = acc_q[ENV_BITS-1 -: 7];
endmodule

// File: rtl/sine_envelope.sv
// sine_envelope: captures one sine sample per frame, scales it by the ADSR level with a
// 7-step serial shift-add multiply and emits offset-binary output at phase 17.
module sine_envelope
    import sine_pkg::*;
#(
    parameter int ENV_BITS  = 12,
    parameter int RATE_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           subsample_phase,
    input  logic [6:0]           sample_in,
    input  logic                 gate,
    input  logic [RATE_BITS-1:0] attack_rate,
    input  logic [RATE_BITS-1:0] decay_rate,
    input  logic [RATE_BITS-1:0] sustain_level,
    input  logic [RATE_BITS-1:0] release_rate,
    output logic [6:0]           out,
    output logic                 out_valid,
    output logic [2:0]           env_state,
    output logic [6:0]           env_level
);
    logic capture, mul, sign_q, sign_d, out_valid_q, out_valid_d;
    logic [2:0] bit_idx;
    logic [6:0] mag_q, mag_d, out_q, out_d, m;
    logic [13:0] prod_q, prod_d, addend;
    assign capture = subsample_phase == PH_CAPTURE;
    assign mul     = subsample_phase >= PH_MUL_FIRST && subsample_phase <= PH_MUL_LAST;
    // Phases 10..16 map to bits 0..6 through the low three phase bits alone.
    assign bit_idx = subsample_phase[2:0] - PH_MUL_FIRST[2:0];
    assign addend  = 14'(mag_q) << bit_idx;
    assign m       = prod_q[13:7];
    adsr_fsm #(.ENV_BITS(ENV_BITS), .RATE_BITS(RATE_BITS)) u_adsr (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (capture),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env_state     (env_state),
        .env_level     (env_level)
    );
    always_comb begin
        sign_d      = sign_q;
        mag_d       = mag_q;
        prod_d      = prod_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (capture) begin
            sign_d = sample_in < MIDSCALE;
            mag_d  = sign_d ? MIDSCALE - sample_in : sample_in - MIDSCALE;
            prod_d = '0;
        end
        if (mul && env_level[bit_idx]) prod_d = prod_q + addend;
        if (subsample_phase == PH_OUT) begin
            out_d       = sign_q ? MIDSCALE - m : MIDSCALE + m;
            out_valid_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            mag_q       <= '0;
            prod_q      <= '0;
            out_q       <= MIDSCALE;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            prod_q      <= prod_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign out       = out_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sine_envelope.sv
// tb_sine_envelope: directed ADSR/multiply checks; frames are shortened to 20 phases except
// one full 256-phase frame, since the design only acts on phases 9..17.
module tb_sine_envelope;
    import sine_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, gate = 1'b0;
    logic [7:0] subsample_phase = 8'd0;
    logic [6:0] sample_in = 7'd64;
    logic [3:0] attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;
    logic [6:0] out, env_level;
    logic out_valid;
    logic [2:0] env_state;
    int vecs = 0, errs = 0, frame_len = 20;

    sine_envelope dut (
        .clk(clk), .rst_n(rst_n), .subsample_phase(subsample_phase), .sample_in(sample_in),
        .gate(gate), .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .out(out), .out_valid(out_valid), .env_state(env_state), .env_level(env_level)
    );

    always #5 clk = ~clk;
    always @(negedge clk)
        subsample_phase = (int'(subsample_phase) >= frame_len - 1) ? 8'd0 : subsample_phase + 8'd1;

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_out();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (subsample_phase != PH_OUT && n < 300);
        #1;
        if (subsample_phase != PH_OUT) chk("frame_timeout", n, 0);
    endtask

    task automatic expect_frame(input string tag, input int st, input int lvl);
        frame_out();
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_state"}, int'(env_state), st);
        chk({tag, "_level"}, int'(env_level), lvl);
    endtask

    initial begin
        int pulses, pph, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 64);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_state", int'(env_state), 0);
        chk("rst_level", int'(env_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sample_in = 7'd127;
        for (int i = 0; i < 10; i++) begin
            expect_frame("idle", 0, 0);
            chk("idle_out", int'(out), 64);
        end
        attack_rate = 4'd15; decay_rate = 4'd0; sustain_level = 4'd15; release_rate = 4'd0;
        gate = 1'b1;
        expect_frame("att0", 1, 0);
        for (int k = 1; k < 256; k++) begin
            expect_frame("attack", 1, k >> 1);
            chk("attack_out", int'(out), 64 + ((63 * (k >> 1)) >> 7));
        end
        expect_frame("att_sat", 2, 127);
        chk("att_sat_out", int'(out), 126);
        sample_in = 7'd0;
        expect_frame("hold0", 2, 127);
        chk("hold0_out", int'(out), 1);
        sample_in = 7'd127;
        expect_frame("hold127", 2, 127);
        chk("hold127_out", int'(out), 126);
        sample_in = 7'd64;
        expect_frame("hold64", 2, 127);
        chk("hold64_out", int'(out), 64);
        frame_len = 256;
        pulses = 0;
        pph = -1;
        repeat (256) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                pph = int'(subsample_phase);
            end
        end
        chk("pulse_count", pulses, 1);
        chk("pulse_phase", pph, 17);
        chk("long_level", int'(env_level), 127);
        frame_len = 20;
        decay_rate = 4'd15;
        sustain_level = 4'd8;
        for (int d = 1; d < 128; d++) expect_frame("decay", 2, (4091 - 16 * d) >> 5);
        expect_frame("sustain", 3, 64);
        sustain_level = 4'd9;
        expect_frame("sus_live9", 3, 72);
        sustain_level = 4'd8;
        expect_frame("sus_live8", 3, 64);
        sample_in = 7'd127;
        gate = 1'b0;
        expect_frame("rel1", 4, 64);
        chk("rel1_out", int'(out), 95);
        for (int r = 2; r <= 17; r++) expect_frame("release", 4, (2049 - r) >> 5);
        gate = 1'b1;
        expect_frame("retrig", 1, 64);
        chk("retrig_out", int'(out), 95);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (subsample_phase != 8'd12 && n < 100);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out", int'(out), 64);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_state", int'(env_state), 0);
        chk("midrst_level", int'(env_level), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pph = -1;
        n = 0;
        while (pph < 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) pph = int'(subsample_phase);
        end
        chk("post_rst_phase", pph, 17);
        chk("post_rst_out", int'(out), 64);
        chk("post_rst_state", int'(env_state), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
